laser_sweep_ctrl: RTL



---
 rtl/laser_pkg.sv | 41 ++++
 rtl/laser_grid_iter.sv | 40 ++++
 rtl/laser_sweep_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/laser_pkg.sv
// ---------------------------------------------------------------------------
// laser_pkg
// Shared definitions for the two-circle laser-coverage sweep controller:
// grid/count widths, controller state encoding, the default (8,8) start
// center and the four seed corners used when LASER_CORNER_SEED_EN is defined.
// No ports (package).
// ---------------------------------------------------------------------------
package laser_pkg;

   localparam int GRID_W = 4;             // coordinate width, grid 0..15
   localparam int CNT_W  = 6;             // coverage count, holds 0..40
   localparam int IDX_W  = 2 * GRID_W;    // raster index width (256 cells)

   localparam logic [GRID_W-1:0] GRID_MAX = {GRID_W{1'b1}};
   localparam logic [GRID_W-1:0] DEF_X    = GRID_W'(8);
   localparam logic [GRID_W-1:0] DEF_Y    = GRID_W'(8);

   // SEED keeps its encoding in every build; it is only reachable when the
   // corner-seed feature is compiled in.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEED     = 3'd1,
      SWEEP_C2 = 3'd2,
      SWEEP_C1 = 3'd3,
      CHECK    = 3'd4,
      FINISH   = 3'd5
   } state_t;

   // Seed corner k as {x, y}: (15,0), (15,15), (0,15), (0,0).
   function automatic logic [IDX_W-1:0] corner_xy(input logic [1:0] k);
      logic [IDX_W-1:0] r;
      case (k)
         2'd0:    r = {GRID_MAX, {GRID_W{1'b0}}};
         2'd1:    r = {GRID_MAX, GRID_MAX};
         2'd2:    r = {{GRID_W{1'b0}}, GRID_MAX};
         default: r = {{GRID_W{1'b0}}, {GRID_W{1'b0}}};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/laser_grid_iter.sv
// ---------------------------------------------------------------------------
// laser_grid_iter
// Raster counter over the 16x16 candidate grid, x fastest. Wraps 255 -> 0 so
// consecutive sweeps need no explicit clear. The seed phase reuses the low
// two bits of x as the corner index.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   clr   in   force index to 0 (priority over adv)
//   adv   in   advance to the next raster position
//   x, y  out  current raster coordinates
//   last  out  high at raster position (15,15)
// ---------------------------------------------------------------------------
module laser_grid_iter
   import laser_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   output logic [GRID_W-1:0] x,
   output logic [GRID_W-1:0] y,
   output logic              last
);

   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         idx <= '0;
      end else if (adv) begin
         idx <= idx + 1'b1;
      end
   end

   assign x    = idx[GRID_W-1:0];
   assign y    = idx[IDX_W-1:GRID_W];
   assign last = &idx;

endmodule

// File: rtl/laser_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// laser_sweep_ctrl
// Sequencer for the two-circle coverage search. Sweeps all C2 candidates with
// C1 fixed, then all C1 candidates with C2 fixed, alternating until a sweep
// brings no strict improvement (after at least two sweeps) or MAX_PASS sweeps
// have run. One candidate pair is evaluated at a time over EVAL_REQ/EVAL_ACK.
//
// Optional feature macro: LASER_CORNER_SEED_EN -- evaluates the four corner
// pairs (C1 = C2 = corner) before the first sweep and starts from the best.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   START                 one-cycle job request, honored only in IDLE
//   BUSY                  job in progress (state != IDLE)
//   DONE                  one-cycle result pulse
//   C1X, C1Y, C2X, C2Y    best centers, updated on the DONE cycle
//   EVAL_REQ              evaluation request
//   EVAL_C1X..EVAL_C2Y    candidate pair, stable while EVAL_REQ is high
//   EVAL_ACK, EVAL_CNT    evaluator completion and coverage count
//   state_dbg             current controller state (state_t encoding)
//
// Handshake: EVAL_REQ rises with stable coordinates and holds until the edge
// that samples EVAL_ACK high; it is then low for exactly one cycle before the
// next request. EVAL_ACK while EVAL_REQ is low is ignored.
// ---------------------------------------------------------------------------
module laser_sweep_ctrl
   import laser_pkg::*;
#(
   parameter int MAX_PASS = 8
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic [GRID_W-1:0] C1X,
   output logic [GRID_W-1:0] C1Y,
   output logic [GRID_W-1:0] C2X,
   output logic [GRID_W-1:0] C2Y,
   output logic              EVAL_REQ,
   output logic [GRID_W-1:0] EVAL_C1X,
   output logic [GRID_W-1:0] EVAL_C1Y,
   output logic [GRID_W-1:0] EVAL_C2X,
   output logic [GRID_W-1:0] EVAL_C2Y,
   input  logic              EVAL_ACK,
   input  logic [CNT_W-1:0]  EVAL_CNT,
   output logic [2:0]        state_dbg
);

   localparam int PASS_W = ($clog2(MAX_PASS + 1) < 2) ? 2 : $clog2(MAX_PASS + 1);

   state_t state, next_state;

   logic              req_q;
   logic              improved;
   logic [PASS_W-1:0] pass;
   logic [CNT_W-1:0]  best_score;
   logic [GRID_W-1:0] b1x, b1y, b2x, b2y;
   logic [GRID_W-1:0] c1x_q, c1y_q, c2x_q, c2y_q;

   logic              it_clr, it_adv, it_last;
   logic [GRID_W-1:0] it_x, it_y;
   logic [IDX_W-1:0]  corner;

   logic in_eval, ack_fire, better, seed_last, stop;

   assign in_eval   = (state == SEED) || (state == SWEEP_C2) || (state == SWEEP_C1);
   assign ack_fire  = in_eval && req_q && EVAL_ACK;
   assign better    = EVAL_CNT > best_score;
   assign seed_last = (it_x[1:0] == 2'd3);
   assign stop      = (pass == PASS_W'(MAX_PASS)) ||
                      ((pass >= PASS_W'(2)) && !improved);
   assign corner    = corner_xy(it_x[1:0]);

   // Cleared when a job starts and again when the seed phase hands over to
   // the first sweep; otherwise the natural 255 -> 0 wrap restarts a sweep.
   assign it_clr = ((state == IDLE) && START) ||
                   ((state == SEED) && ack_fire && seed_last);
   assign it_adv = ack_fire;

   laser_grid_iter u_iter (
      .clk  (CLK),
      .rst  (RST),
      .clr  (it_clr),
      .adv  (it_adv),
      .x    (it_x),
      .y    (it_y),
      .last (it_last)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (START) begin
`ifdef LASER_CORNER_SEED_EN
               next_state = SEED;
`else
               next_state = SWEEP_C2;
`endif
            end
         end
         SEED:     if (ack_fire && seed_last) next_state = SWEEP_C2;
         SWEEP_C2: if (ack_fire && it_last)   next_state = CHECK;
         SWEEP_C1: if (ack_fire && it_last)   next_state = CHECK;
         // An odd pass count means the C2 sweep just finished.
         CHECK:    next_state = stop ? FINISH : (pass[0] ? SWEEP_C1 : SWEEP_C2);
         FINISH:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      EVAL_C1X = b1x;
      EVAL_C1Y = b1y;
      EVAL_C2X = b2x;
      EVAL_C2Y = b2y;
      case (state)
         SEED: begin
            {EVAL_C1X, EVAL_C1Y} = corner;
            {EVAL_C2X, EVAL_C2Y} = corner;
         end
         SWEEP_C2: {EVAL_C2X, EVAL_C2Y} = {it_x, it_y};
         SWEEP_C1: {EVAL_C1X, EVAL_C1Y} = {it_x, it_y};
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         req_q      <= 1'b0;
         improved   <= 1'b0;
         pass       <= '0;
         best_score <= '0;
         b1x <= '0; b1y <= '0; b2x <= '0; b2y <= '0;
         c1x_q <= '0; c1y_q <= '0; c2x_q <= '0; c2y_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  best_score <= '0;
                  pass       <= '0;
                  improved   <= 1'b0;
                  req_q      <= 1'b1;
`ifdef LASER_CORNER_SEED_EN
                  // First corner is the tie winner if no corner beats 0.
                  {b1x, b1y} <= corner_xy(2'd0);
                  {b2x, b2y} <= corner_xy(2'd0);
`else
                  b1x <= DEF_X; b1y <= DEF_Y;
                  b2x <= DEF_X; b2y <= DEF_Y;
`endif
               end
            end
            SEED, SWEEP_C2, SWEEP_C1: begin
               if (!req_q) begin
                  req_q <= 1'b1;
               end else if (EVAL_ACK) begin
                  req_q <= 1'b0;
                  if (better) begin
                     best_score <= EVAL_CNT;
                     if (state == SEED) begin
                        {b1x, b1y} <= corner;
                        {b2x, b2y} <= corner;
                     end else if (state == SWEEP_C2) begin
                        b2x <= it_x; b2y <= it_y;
                        improved <= 1'b1;
                     end else begin
                        b1x <= it_x; b1y <= it_y;
                        improved <= 1'b1;
                     end
                  end
                  if ((state != SEED) && it_last) begin
                     pass <= pass + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (stop) begin
                  c1x_q <= b1x; c1y_q <= b1y;
                  c2x_q <= b2x; c2y_q <= b2y;
               end else begin
                  improved <= 1'b0;
                  req_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign BUSY      = (state != IDLE);
   assign DONE      = (state == FINISH);
   assign EVAL_REQ  = req_q;
   assign C1X       = c1x_q;
   assign C1Y       = c1y_q;
   assign C2X       = c2x_q;
   assign C2Y       = c2y_q;
   assign state_dbg = state;

endmodule
